// File: rtl/piso_tx_pkg.sv
// Shared sequencer constants for the serial transmit path: FSM state
// encodings and the prescaler width helper.
package piso_tx_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_SHIFT = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

  // A divide-by-1 prescaler still needs one bit of counter storage.
  function automatic int prescaleWidth(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/piso_tx_mod_counter.sv
// Modulo-M counter that advances while enabled and pulses o_wrap on the
// cycle it rolls over from M-1 back to 0.
module mod_counter
  import piso_tx_pkg::*;
#(
  parameter int M = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_wrap
);

  localparam int W = prescaleWidth(M);
  localparam logic [W-1:0] LAST = W'(M - 1);

  logic [W-1:0] r_count;

  assign o_wrap = i_en && (r_count == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: captures an N-bit word and shifts it
// out MSB first, holding each bit for DIV clock cycles.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int N        = 4,
  parameter int DIV      = 4,
  parameter bit IDLE_LVL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         load,
  output logic         ready,
  output logic         sout,
  output logic         busy,
  output logic         done
);

  localparam int BW = $clog2(N + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  logic [STATE_W-1:0] r_state;
  logic [N-1:0]       r_shift;
  logic [BW-1:0]      r_bitCnt;
  logic               r_sout;
  logic               w_bitTick;
  logic               w_shiftEn;
  logic [N-1:0]       w_shiftNext;

  assign w_shiftEn   = (r_state == ST_SHIFT);
  assign w_shiftNext = r_shift << 1;

  // The prescaler sits at zero outside SHIFT, so every word starts on a
  // full DIV-cycle bit period.
  mod_counter #(
    .M(DIV)
  ) u_prescale (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_shiftEn),
    .o_wrap(w_bitTick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_sout   <= IDLE_LVL;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_state  <= ST_SHIFT;
            r_shift  <= din;
            r_sout   <= din[N-1];
            r_bitCnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_bitTick) begin
            if (r_bitCnt == LAST_BIT) begin
              r_state  <= ST_DONE;
              r_sout   <= IDLE_LVL;
              r_bitCnt <= BW'(N);
            end else begin
              r_shift  <= w_shiftNext;
              r_sout   <= w_shiftNext[N-1];
              r_bitCnt <= r_bitCnt + BW'(1);
            end
          end
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          r_bitCnt <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_sout  <= IDLE_LVL;
        end
      endcase
    end
  end

  assign ready = (r_state == ST_IDLE);
  assign busy  = (r_state == ST_SHIFT);
  assign done  = (r_state == ST_DONE);
  assign sout  = r_sout;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: three instances (DIV=4, DIV=1, idle-high)
// share stimulus and are compared against a cycle-level behavioural model.
module tb_piso_tx;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic [NB-1:0] din = '0;
  logic [2:0]    ready, busy, done, sout;

  int divOf[3]    = '{4, 1, 4};
  logic idleOf[3] = '{1'b0, 1'b0, 1'b1};

  // Model: mode 0 idle, 1 shifting (mElapsed = 1..NB*div), 2 done.
  int            mMode[3];
  int            mElapsed[3];
  logic [NB-1:0] mWord[3];

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  piso_tx #(.N(NB), .DIV(4), .IDLE_LVL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .load(load),
    .ready(ready[0]), .sout(sout[0]), .busy(busy[0]), .done(done[0]));

  piso_tx #(.N(NB), .DIV(1), .IDLE_LVL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .din(din), .load(load),
    .ready(ready[1]), .sout(sout[1]), .busy(busy[1]), .done(done[1]));

  piso_tx #(.N(NB), .DIV(4), .IDLE_LVL(1'b1)) dut2 (
    .clk(clk), .rst(rst), .din(din), .load(load),
    .ready(ready[2]), .sout(sout[2]), .busy(busy[2]), .done(done[2]));

  // Expected {ready, busy, done, sout}; the serial bit is picked by elapsed
  // time within the word divided by the bit period.
  function automatic logic [3:0] expVec(input int id);
    logic s;
    s = idleOf[id];
    if (mMode[id] == 1) s = mWord[id][NB - 1 - (mElapsed[id] - 1) / divOf[id]];
    return {mMode[id] == 0, mMode[id] == 1, mMode[id] == 2, s};
  endfunction

  function automatic logic [3:0] obsVec(input int id);
    return {ready[id], busy[id], done[id], sout[id]};
  endfunction

  // Called at a falling edge: drives inputs for the current cycle, advances
  // the model across the rising edge, returns at the next falling edge.
  task automatic applyStimulus(input logic r, input logic l, input logic [NB-1:0] d);
    rst = r;
    load = l;
    din = d;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!r) begin
        mMode[i] = 0;
        mElapsed[i] = 0;
      end else begin
        case (mMode[i])
          0: if (l) begin
            mMode[i] = 1;
            mElapsed[i] = 1;
            mWord[i] = d;
          end
          1: if (mElapsed[i] == NB * divOf[i]) mMode[i] = 2;
             else mElapsed[i]++;
          default: mMode[i] = 0;
        endcase
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] obs, ex;
    applyStimulus(1'b0, 1'b1, NB'($urandom));
    applyStimulus(1'b0, 1'b1, NB'($urandom));
    for (int i = 0; i < 3; i++) begin
      obs = obsVec(i);
      ex = {1'b1, 1'b0, 1'b0, idleOf[i]};
      testsRun++;
      if (obs !== ex) begin
        testsFailed++;
        $display("[TB] FAIL reset dut%0d: got rdy/busy/done/sout=%b expected %b", i, obs, ex);
      end
    end
    applyStimulus(1'b1, 1'b1, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      obs = obsVec(i);
      ex = expVec(i);
      testsRun++;
      if (obs !== ex || busy[i] !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL first_load_after_reset dut%0d: got %b expected %b", i, obs, ex);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] obs, ex;
    int doneCycle;
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 4'b1011);
    doneCycle = -1;
    for (int c = 1; c <= 18; c++) begin
      obs = obsVec(0);
      ex = expVec(0);
      testsRun++;
      if (obs !== ex) begin
        testsFailed++;
        $display("[TB] FAIL basic cycle %0d: got %b expected %b", c, obs, ex);
      end
      if (done[0] === 1'b1 && doneCycle < 0) doneCycle = c;
      applyStimulus(1'b1, (c < 17) ? 1'($urandom) : 1'b0, NB'($urandom));
    end
    testsRun++;
    if (doneCycle != NB * divOf[0] + 1) begin
      testsFailed++;
      $display("[TB] FAIL basic_done_cycle: got %0d expected %0d", doneCycle, NB * divOf[0] + 1);
    end
  endtask

  task automatic test_load_held();
    logic [3:0] obs, ex;
    applyStimulus(1'b0, 1'b0, '0);
    for (int c = 0; c < 37; c++) begin
      obs = obsVec(0);
      ex = expVec(0);
      testsRun++;
      if (obs !== ex) begin
        testsFailed++;
        $display("[TB] FAIL load_held cycle %0d: got %b expected %b", c, obs, ex);
      end
      applyStimulus(1'b1, 1'b1, (c < 5) ? 4'b0110 : 4'b1111);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] obs, ex;
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 4'b1101);
    for (int c = 1; c <= 20; c++) begin
      obs = obsVec(0);
      ex = expVec(0);
      testsRun++;
      if (obs !== ex || (c >= 8 && done[0] !== 1'b0)) begin
        testsFailed++;
        $display("[TB] FAIL reset_mid cycle %0d: got %b expected %b", c, obs, ex);
      end
      applyStimulus((c == 7) ? 1'b0 : 1'b1, 1'b0, NB'($urandom));
    end
  endtask

  task automatic test_div1();
    logic [3:0] obs, ex;
    applyStimulus(1'b0, 1'b0, '0);
    for (int c = 0; c < 14; c++) begin
      obs = obsVec(1);
      ex = expVec(1);
      testsRun++;
      if (obs !== ex) begin
        testsFailed++;
        $display("[TB] FAIL div1 cycle %0d: got %b expected %b", c, obs, ex);
      end
      applyStimulus(1'b1, 1'b1, (c < 6) ? 4'b1000 : 4'b1010);
    end
  endtask

  task automatic test_idle_high();
    logic [3:0] obs, ex;
    applyStimulus(1'b0, 1'b0, '0);
    for (int c = 0; c < 22; c++) begin
      obs = obsVec(2);
      ex = expVec(2);
      testsRun++;
      if (obs !== ex) begin
        testsFailed++;
        $display("[TB] FAIL idle_high cycle %0d: got %b expected %b", c, obs, ex);
      end
      applyStimulus(1'b1, (c == 0), 4'b0000);
    end
  endtask

  task automatic test_random();
    logic [3:0] obs, ex;
    applyStimulus(1'b0, 1'b0, '0);
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 3; i++) begin
        obs = obsVec(i);
        ex = expVec(i);
        testsRun++;
        if (obs !== ex) begin
          testsFailed++;
          $display("[TB] FAIL random dut%0d cycle %0d: got %b expected %b", i, c, obs, ex);
        end
      end
      applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0), NB'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      mMode[i] = 0;
      mElapsed[i] = 0;
      mWord[i] = '0;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_load_held();
    test_reset_mid();
    test_div1();
    test_idle_high();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL provide parameter N, default 4: number of data bits per word.
REQ-002 SHALL provide parameter DIV, default 4: clock cycles per serial bit (DIV >= 1).
REQ-003 SHALL provide parameter IDLE_LVL, default 0: level driven on sout when no bit is being sent.
REQ-004 SHALL provide port clk  input  1  rising-edge system clock.
REQ-005 SHALL provide port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL provide port din  input  N  parallel word to serialize.
REQ-007 SHALL provide port load  input  1  request to accept din.
REQ-008 SHALL provide port ready  output  1  high when a load is accepted this cycle.
REQ-009 SHALL provide port sout  output  1  serial data, MSB first.
REQ-010 SHALL provide port busy  output  1  high while bits are being shifted.
REQ-011 SHALL provide port done  output  1  one-cycle pulse after the last bit.

Function
REQ-012 SHALL implement states IDLE, SHIFT and DONE.
REQ-013 SHALL accept a word on the rising edge where state = IDLE and load = 1, capturing din and entering SHIFT.
REQ-014 SHALL assert ready = 1 only in IDLE and busy = 1 only in SHIFT.
REQ-015 SHALL assert done = 1 only in DONE, with DONE lasting exactly one cycle before returning to IDLE.
REQ-016 SHALL drive sout = captured bit N-1 for the first DIV cycles of SHIFT, then bits N-2 down to 0 for DIV cycles each.
REQ-017 SHALL take exactly N*DIV cycles in SHIFT: an accept edge at cycle k puts done high in cycle k+N*DIV+1 and ready high in cycle k+N*DIV+2.
REQ-018 SHALL drive sout = IDLE_LVL in IDLE and DONE.
REQ-019 SHALL ignore load in SHIFT and DONE; that data is dropped and is not queued.
REQ-020 SHALL leave the word in flight unaffected by din changes after capture.
REQ-021 SHALL, with DIV = 1, emit one bit per cycle with no gap cycles inside the word.
REQ-022 SHALL use a prescaler counter of width max(1, clog2(DIV)) that wraps from DIV-1 to 0.
REQ-023 SHALL use a bit counter of width clog2(N+1), with no wrap beyond N.
REQ-024 SHALL keep sout registered so that it is glitch-free.

Reset
REQ-025 SHALL, when rst = 0 at a rising edge, force state = IDLE, ready = 1, busy = 0, done = 0, sout = IDLE_LVL, counters = 0 and shift register = 0.
REQ-026 SHALL give rst priority over load at the same edge.
REQ-027 SHALL abort any word in flight on reset, producing no done pulse.
REQ-028 SHALL accept load on the first edge after rst returns high.

Structure
REQ-029 SHALL place the state encoding (IDLE, SHIFT, DONE localparams) in a shared package alongside the codebase's other sequencer constants.
REQ-030 SHALL implement the prescaler as one sub-module, mod_counter (parameter M, synchronous active-low rst, enable input, wrap-pulse output).
REQ-031 SHALL keep shift register, bit counter and FSM inside piso_tx.

Verification
REQ-032 SHALL cover: N=4, DIV=4, din=4'b1011, load pulsed in cycle 0 -> sout = 1,0,1,1 for 4 cycles each over cycles 1-16, done = 1 in cycle 17, ready = 1 in cycle 18.
REQ-033 SHALL cover: load held high with din=4'b0110 changed to 4'b1111 in cycle 5 -> serial output is 0,1,1,0; second load ignored until ready; then 1,1,1,1 is sent.
REQ-034 SHALL cover: rst = 0 in cycle 7 of a word -> next cycle sout = IDLE_LVL, busy = 0, ready = 1, and no done pulse.
REQ-035 SHALL cover: DIV=1, N=4, din=4'b1000, load held high -> sout = 1,0,0,0 in cycles 1-4, done in cycle 5, next word accepted in cycle 6.
REQ-036 SHALL cover: IDLE_LVL=1, din=4'b0000 -> sout = 1 when idle, 0 for 16 cycles, then 1 again.
REQ-037 SHALL cover: rst = 0 and load = 1 at the same edge -> no word accepted, all outputs at reset values.
